// File: rtl/timer_arbiter.sv
// Shared countdown timer handed out to N requesters by round-robin arbitration.
// One owner at a time runs the counter to zero and receives a one-cycle done pulse.
module timer_arbiter #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned N     = 4
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [N-1:0]       req_i,
   input  logic [N*WIDTH-1:0] count_i,
   output logic [N-1:0]       gnt_o,
   output logic [N-1:0]       done_o,
   output logic               busy_o
);

   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned SUM_W = IDX_W + 1;
   localparam logic [N-1:0] ONE  = N'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [WIDTH-1:0]   cnt_q, cnt_d;
   logic [N-1:0]       gnt_d, done_d;
   logic               busy_d;

   logic [WIDTH-1:0]   count_arr [N];
   logic [IDX_W-1:0]   pick_c;
   logic               pick_vld_c;

   for (genvar g = 0; g < N; g++) begin : g_count
      assign count_arr[g] = count_i[g*WIDTH +: WIDTH];
   end

   // Round-robin search starting just after the previous owner, wrapping at N-1.
   always_comb begin
      logic [SUM_W-1:0] idx;
      pick_c     = '0;
      pick_vld_c = 1'b0;
      idx        = '0;
      for (int i = 1; i <= int'(N); i++) begin
         idx = {1'b0, owner_q} + SUM_W'(i);
         if (idx >= SUM_W'(N)) begin
            idx = idx - SUM_W'(N);
         end
         if (!pick_vld_c && req_i[idx[IDX_W-1:0]]) begin
            pick_c     = idx[IDX_W-1:0];
            pick_vld_c = 1'b1;
         end
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      gnt_d   = '0;
      done_d  = '0;
      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (pick_vld_c) begin
               owner_d = pick_c;
               cnt_d   = count_arr[pick_c];
               gnt_d   = ONE << pick_c;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // Abort wins over expiry when the owner drops its request.
            if (!req_i[owner_q]) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - WIDTH'(1);
               gnt_d = ONE << owner_q;
            end else begin
               gnt_d   = ONE << owner_q;
               done_d  = ONE << owner_q;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and registered outputs; owner_q doubles as the round-robin pointer.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         owner_q <= IDX_W'(N - 1);
         cnt_q   <= '0;
         gnt_o   <= '0;
         done_o  <= '0;
         busy_o  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         gnt_o   <= gnt_d;
         done_o  <= done_d;
         busy_o  <= busy_d;
      end
   end

endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a deadline-based model.
module tb_timer_arbiter;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned N     = 4;
   localparam int unsigned IW    = 2;

   logic               clk_i = 1'b0;
   logic               rst_ni = 1'b0;
   logic [N-1:0]       req_i = '0;
   logic [N*WIDTH-1:0] count_i;
   logic [N-1:0]       gnt_o, done_o;
   logic               busy_o;
   logic [WIDTH-1:0]   cnt_a [N];

   int n_checks = 0;
   int n_pass   = 0;

   for (genvar g = 0; g < N; g++) begin : g_pack
      assign count_i[g*WIDTH +: WIDTH] = cnt_a[g];
   end

   timer_arbiter #(.WIDTH(WIDTH), .N(N)) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .req_i  (req_i),
      .count_i(count_i),
      .gnt_o  (gnt_o),
      .done_o (done_o),
      .busy_o (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Model: owner, absolute deadline edge, phase 0=idle 1=owned 2=expired.
   int m_phase = 0;
   int m_owner = 0;
   int m_last  = N - 1;
   int m_cyc   = 0;
   int m_dl    = 0;

   always @(posedge clk_i or negedge rst_ni) begin
      int cur, k;
      bit found;
      if (!rst_ni) begin
         m_phase <= 0;
         m_last  <= N - 1;
         m_owner <= 0;
         m_cyc   <= 0;
         m_dl    <= 0;
      end else begin
         cur   = m_cyc + 1;
         found = 0;
         m_cyc <= cur;
         if (m_phase == 0) begin
            for (int s = 1; s <= int'(N); s++) begin
               k = (m_last + s) % N;
               if (!found && req_i[IW'(k)]) begin
                  found    = 1;
                  m_owner <= k;
                  m_last  <= k;
                  m_dl    <= cur + int'(cnt_a[IW'(k)]) + 1;
                  m_phase <= 1;
               end
            end
         end else if (m_phase == 1) begin
            if (!req_i[IW'(m_owner)]) m_phase <= 0;
            else if (cur == m_dl)     m_phase <= 2;
         end else begin
            m_phase <= 0;
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk_i) begin
      int eg, ed;
      eg = (m_phase != 0) ? (1 << m_owner) : 0;
      ed = (m_phase == 2) ? (1 << m_owner) : 0;
      chk("model_gnt", int'(gnt_o), eg);
      chk("model_done", int'(done_o), ed);
      chk("model_busy", int'(busy_o), (m_phase != 0) ? 1 : 0);
   end

   task automatic tick();
      @(negedge clk_i);
   endtask

   task automatic do_reset();
      req_i  = '0;
      rst_ni = 1'b0;
      tick();
      tick();
      rst_ni = 1'b1;
   endtask

   function automatic int oh2idx(input logic [N-1:0] v);
      int r = -1;
      for (int i = 0; i < int'(N); i++) if (v[i]) r = i;
      return r;
   endfunction

   initial begin
      int order [5];
      int gcyc [5];
      int dcyc [5];
      int ng, nd, hit;
      logic [N-1:0] pg, pd;
      for (int i = 0; i < int'(N); i++) cnt_a[i] = '0;
      tick();
      rst_ni = 1'b1;

      // Single requester, count 5.
      chk("rst_gnt", int'(gnt_o), 0);
      chk("rst_busy", int'(busy_o), 0);
      cnt_a[0] = 8'd5; req_i = 4'b0001;
      tick();
      chk("t1_gnt", int'(gnt_o), 1);
      chk("t1_busy", int'(busy_o), 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t1_done_early", int'(done_o), 0);
      end
      tick();
      chk("t1_done", int'(done_o), 1);
      req_i = '0;
      tick();
      chk("t1_busy_after", int'(busy_o), 0);
      chk("t1_gnt_after", int'(gnt_o), 0);

      // All four requesting, counts 2: round-robin order and spacing.
      do_reset();
      for (int i = 0; i < int'(N); i++) cnt_a[i] = 8'd2;
      req_i = 4'b1111;
      ng = 0; nd = 0; pg = '0; pd = '0;
      for (int c = 0; c < 40 && ng < 5; c++) begin
         tick();
         if (gnt_o != 0 && pg == 0) begin
            order[ng] = oh2idx(gnt_o); gcyc[ng] = c; ng++;
         end
         if (done_o != 0 && pd == 0 && nd < 5) begin
            dcyc[nd] = c; nd++;
         end
         pg = gnt_o; pd = done_o;
      end
      chk("t2_grant_count", ng, 5);
      for (int i = 0; i < 5; i++) if (i < ng) chk("t2_order", order[i], i % 4);
      for (int i = 1; i < 5; i++) if (i < ng) chk("t2_gap", gcyc[i] - dcyc[i-1], 2);
      req_i = '0;

      // Zero count expires one cycle after grant.
      do_reset();
      cnt_a[1] = 8'd0; req_i = 4'b0010;
      tick();
      chk("t3_gnt", int'(gnt_o), 2);
      tick();
      chk("t3_done", int'(done_o), 2);
      req_i = '0;

      // Abort of owner 0, pending requester 2 takes over.
      do_reset();
      cnt_a[0] = 8'd10; cnt_a[2] = 8'd3; req_i = 4'b0101;
      tick();
      chk("t4_gnt0", int'(gnt_o), 1);
      tick(); tick(); tick();
      req_i = 4'b0100;
      tick();
      chk("t4_abort_gnt", int'(gnt_o), 0);
      chk("t4_abort_busy", int'(busy_o), 0);
      chk("t4_abort_done", int'(done_o), 0);
      tick();
      chk("t4_gnt2", int'(gnt_o), 4);
      req_i = '0;

      // Asynchronous reset mid-run, then priority restarts at requester 0.
      do_reset();
      cnt_a[1] = 8'd7; req_i = 4'b0010;
      tick();
      chk("t5_gnt1", int'(gnt_o), 2);
      tick(); tick(); tick();
      #2 rst_ni = 1'b0;
      #1;
      chk("t5_async_gnt", int'(gnt_o), 0);
      chk("t5_async_busy", int'(busy_o), 0);
      chk("t5_async_done", int'(done_o), 0);
      tick();
      rst_ni = 1'b1; req_i = 4'b0011;
      tick();
      chk("t5_regrant", int'(gnt_o), 1);
      req_i = '0;

      // count_i change during the run is ignored.
      do_reset();
      cnt_a[0] = 8'd5; req_i = 4'b0001;
      tick();
      cnt_a[0] = 8'd200;
      hit = -1;
      for (int i = 1; i <= 20 && hit < 0; i++) begin
         tick();
         if (done_o != 0) hit = i;
      end
      chk("t6_done_latency", hit, 6);
      req_i = '0;

      // Randomized traffic; per-cycle model comparison does the checking.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0) req_i = N'($urandom_range(0, 15));
         for (int i = 0; i < int'(N); i++)
            if ($urandom_range(0, 1) == 0) cnt_a[i] = WIDTH'($urandom_range(0, 6));
         if (!rst_ni) rst_ni = 1'b1;
         else if ($urandom_range(0, 199) == 0) rst_ni = 1'b0;
         tick();
      end
      rst_ni = 1'b1;
      req_i  = '0;
      tick();
      tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/timer_arbiter.md
TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the countdown width in bits.
REQ-002 The block SHALL have parameter N, default 4, legal range 2..8, giving the number of requesters.
REQ-003 Port clk_i  input  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-004 Port rst_ni  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Port req_i  input  N  SHALL carry the per-requester timer request; bit k belongs to requester k.
REQ-006 Port count_i  input  N*WIDTH  SHALL carry the requested cycle counts; requester k uses bits [k*WIDTH +: WIDTH].
REQ-007 Port gnt_o  output  N  SHALL be the one-hot (or zero) grant, marking the current owner of the shared countdown.
REQ-008 Port done_o  output  N  SHALL carry a one-cycle expiry pulse to the owning requester.
REQ-009 Port busy_o  output  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-010 The block SHALL contain exactly one WIDTH-bit down counter, shared among all requesters.
REQ-011 The block SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-012 IDLE with req_i == 0 SHALL remain IDLE; counter holds 0; gnt_o = 0.
REQ-013 IDLE with any req_i bit set SHALL, on the next edge, select owner k by round-robin, load counter <= count_i[k], and enter RUN.
REQ-014 Round-robin SHALL search from (last owner + 1) mod N upward, wrapping at N-1 -> 0; the first set req_i bit wins.
REQ-015 count_i SHALL be sampled only on the grant edge; later changes SHALL be ignored for that run.
REQ-016 In RUN with counter != 0, the counter SHALL decrement by 1 per cycle; it SHALL never wrap below 0.
REQ-017 In RUN with counter == 0 and req_i[owner] high, the next edge SHALL enter DONE.
REQ-018 In DONE, done_o[owner] SHALL be 1 for exactly that cycle; the next edge SHALL enter IDLE.
REQ-019 done_o SHALL be registered (driven from state), one-hot at most, and zero outside DONE.
REQ-020 Latency: a grant that loads count C SHALL produce done_o high exactly C+1 cycles after the grant edge; C = 0 yields done_o 1 cycle after grant.
REQ-021 gnt_o[owner] SHALL be 1 throughout RUN and DONE, and 0 in IDLE.
REQ-022 Abort: in RUN, if req_i[owner] == 0 at an edge, the FSM SHALL go to IDLE, clear the counter, and emit no done_o pulse; the round-robin pointer SHALL still advance past the owner.
REQ-023 Abort and expiry in the same cycle (RUN, counter == 0, req_i[owner] == 0) SHALL resolve as abort.
REQ-024 In DONE, req_i[owner] dropping SHALL be ignored; the done pulse still occurs.
REQ-025 Requests from non-owners SHALL be held pending without effect until IDLE; no preemption.
REQ-026 After DONE or abort, re-arbitration from IDLE SHALL take one idle cycle, so a new grant issues at the second edge after DONE/abort.
REQ-027 A lone requester that keeps req_i high after done_o SHALL be re-granted, starting a new run.

Reset
REQ-028 rst_ni low SHALL immediately (asynchronously) force: FSM IDLE, counter 0, gnt_o 0, done_o 0, busy_o 0.
REQ-029 Reset SHALL set the round-robin pointer so that requester 0 has highest priority at the first arbitration.
REQ-030 Reset asserted mid-RUN or in DONE SHALL abandon the run with no done_o pulse; operation resumes from IDLE after release.

Verification
REQ-031 Reset release, req_i = 0001, count0 = 5 -> gnt_o = 0001 at edge 1, done_o = 0001 exactly 6 cycles later, busy_o low the cycle after.
REQ-032 req_i = 1111, all counts 2 held continuously -> grants in order 0,1,2,3,0; each done_o precedes the next gnt_o by 2 cycles.
REQ-033 count1 = 0, req_i = 0010 -> done_o[1] one cycle after grant; no underflow, counter stays 0.
REQ-034 req0 granted with count 10, req0 dropped after 3 cycles -> IDLE next edge, done_o stays 0, pending req2 granted 2 edges later.
REQ-035 rst_ni pulsed low mid-RUN (counter = 4) -> outputs zero asynchronously, no done_o; next request is arbitrated with requester 0 highest.
REQ-036 count_i changed during RUN (5 -> 200) -> done_o timing still reflects 5.
